ir_dual_dispatch: RTL and testbench
===================================

# ir_dual_dispatch

Dual-issue dispatch controller between the IR-stage instruction queue and the register-read/rename pipeline register. Each cycle it inspects the two oldest queued instructions, decides whether to pop 0, 1 or 2, and latches the popped instructions into the IR→RR pipeline register. It splits a pair when slot 1 depends on slot 0, issues serialising (CSR/fence) instructions alone, and blocks further issue until they complete. It also keeps saturating dual-issue and split statistics counters.

## Interface
- `CNT_WIDTH`, default 16: width of each statistics counter.
- `clk_i`  in  1  clock; all state updates on the rising edge.
- `rstn_i`  in  1  asynchronous, active-low reset.
- `instruction_S_i`  in  id_ir_stage_t [NUM_SCALAR_INSTR]  queue head outputs.
  - Slot 0 is the oldest entry.
  - Slot 1 is the next entry.
  - Each slot is valid when `.instr.valid` is set.
- `empty_i`  in  1  queue empty.
- `flush_i`  in  1  pipeline flush.
- `stall_i`  in  1  downstream cannot accept this cycle.
- `serial_done_i`  in  1  single-cycle pulse: the outstanding serialising instruction has committed.
- `read_head_S_o`  out  logic [NUM_SCALAR_INSTR]  pop strobes, combinational.
  - `[1]` is only ever asserted together with `[0]`.
- `instruction_S_o`  out  id_ir_stage_t [NUM_SCALAR_INSTR]  registered IR→RR pipeline register.
- `serial_busy_o`  out  1  FSM is in the WAIT_SERIAL state.
- `dual_cnt_o`  out  CNT_WIDTH  number of cycles in which 2 instructions issued.
- `split_cnt_o`  out  CNT_WIDTH  number of cycles in which a hazard limited issue to 1 instruction.

## Operation
- **Slot validity.** v0 = `!empty_i & instruction_S_i[0].instr.valid`. v1 = v0 & `instruction_S_i[1].instr.valid`.
- **Dependency hazard (dep).** Slot 0 has `regfile_we`, its `rd` != 0, and slot 1's `rs1` or `rs2` equals that `rd`.
- **Serialising instruction (ser).** Flagged by `instr.stall_csr_fence`.
- **FSM states.** RUN and WAIT_SERIAL. Reset state is RUN.
- **Issue enable (go).** go = state==RUN & !stall_i & !flush_i.
- **Pop decision when go:**
  - !v0: pop none.
  - v0 & ser0: pop slot 0 only.
  - v1 & !dep & !ser1: pop both.
  - Otherwise (v0 only, dep, or ser1): pop slot 0 only.
  - A serialising instruction in slot 1 therefore waits until it reaches slot 0.
- **Pipeline register update when go:**
  - Popped slots are copied into `instruction_S_o`.
  - Non-popped output slots load all-zero, so `.instr.valid`=0.
- **Pipeline register hold.** When `stall_i`=1, `instruction_S_o` holds its value.
- **Bubbles in WAIT_SERIAL.** When state==WAIT_SERIAL and `stall_i`=0, `instruction_S_o` loads zero.
- **FSM transitions.**
  - RUN → WAIT_SERIAL on a cycle where go=1 and slot 0 pops with ser0.
  - WAIT_SERIAL → RUN on `serial_done_i`.
  - No issue occurs in the cycle `serial_done_i` arrives; issue resumes the following cycle.
- **Flush.**
  - Flush has priority over every other condition.
  - `read_head_S_o`=0 in the flush cycle.
  - Next edge: `instruction_S_o` is zeroed and state goes to RUN, even if `serial_done_i` is absent.
  - Counters are not cleared by flush.
- **Counters.** Saturating unsigned counters.
  - `dual_cnt_o` += 1 on each cycle with a two-instruction pop.
  - `split_cnt_o` += 1 on each cycle with go, v1 and a single pop caused by dep or ser1.
  - Both stick at 2^CNT_WIDTH−1 and never wrap.
- **Reset values.**
  - All `instruction_S_o` fields 0.
  - `read_head_S_o`=0.
  - `serial_busy_o`=0.
  - Both counters 0.
  - State RUN.
- **Reset mid-operation.** Reset discards any WAIT_SERIAL state immediately (asynchronous).
- **Out-of-range input.** A slot 1 valid while slot 0 is invalid is ignored.

## Timing
- `read_head_S_o` is combinational from the inputs, `state`, `stall_i` and `flush_i`, within the same cycle.
- The queue advances its head on the same edge that loads `instruction_S_o`.
- Latency is 1 cycle: an instruction at the queue head in cycle N appears on `instruction_S_o` in cycle N+1, given no stall, no flush, RUN state and no hazard.
- Under `stall_i`, neither pops nor output changes occur, so a stalled instruction is never lost or duplicated.
- `serial_busy_o` rises the cycle after the serialising instruction issues.
- `serial_busy_o` falls the cycle after `serial_done_i`.
- Throughput is at most 2 instructions per cycle.
- A serialising instruction costs at least 2 bubble cycles: issue cycle +1 minimum WAIT_SERIAL cycle.

## Test plan
- **Independent pair.**
  - Stimulus: pair (`addi x1`; `addi x2, x3`), no stall.
  - Response: pops = 11; next cycle both output slots valid with matching payloads; `dual_cnt_o`=1.
- **Dependent pair.**
  - Stimulus: slot 0 `add x5`, slot 1 reads `x5`.
  - Response: pops = 01; output slot 1 invalid; `split_cnt_o`=1; next cycle the former slot 1 issues in slot 0.
  - Repeat with `rd`=x0: the pair dual-issues.
- **Serialising instruction.**
  - Stimulus: CSR in slot 0, add in slot 1.
  - Response: pop 01; `serial_busy_o`=1; no pops for 5 cycles until `serial_done_i` pulse; pops resume 1 cycle after the pulse.
- **Stall hold.**
  - Stimulus: `stall_i`=1 for 3 cycles with a full queue head.
  - Response: `read_head_S_o`=00 throughout; outputs unchanged; after release, the instructions appear exactly once.
- **Flush.**
  - Stimulus: flush while in WAIT_SERIAL with valid outputs.
  - Response: pops 00 in the flush cycle; next cycle outputs are zero and `serial_busy_o`=0; counters keep their values.
- **Counter saturation.**
  - Stimulus: CNT_WIDTH=4, 20 consecutive dual-issue cycles.
  - Response: `dual_cnt_o` stops at 15.
  - Async reset asserted mid-burst: all outputs 0 immediately.

Source files
------------

// File: rtl/ir_dual_dispatch.sv
// Dual-issue dispatch from the IR instruction queue head into the IR->RR pipeline register.
// Splits dependent pairs, issues serialising instructions alone and keeps issue statistics.

package ir_dual_dispatch_pkg;
    localparam int NUM_SCALAR_INSTR = 2;

    typedef struct packed {
        logic        valid;
        logic [31:0] pc;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        regfile_we;
        logic        stall_csr_fence;
    } instr_t;

    typedef struct packed {
        instr_t      instr;
        logic [31:0] imm;
    } id_ir_stage_t;
endpackage

module ir_dual_dispatch
    import ir_dual_dispatch_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                        clk_i,
    input  logic                        rstn_i,
    input  id_ir_stage_t                instruction_S_i [NUM_SCALAR_INSTR],
    input  logic                        empty_i,
    input  logic                        flush_i,
    input  logic                        stall_i,
    input  logic                        serial_done_i,
    output logic [NUM_SCALAR_INSTR-1:0] read_head_S_o,
    output id_ir_stage_t                instruction_S_o [NUM_SCALAR_INSTR],
    output logic                        serial_busy_o,
    output logic [CNT_WIDTH-1:0]        dual_cnt_o,
    output logic [CNT_WIDTH-1:0]        split_cnt_o
);

    typedef enum logic {
        RUN         = 1'b0,
        WAIT_SERIAL = 1'b1
    } state_e;

    state_e                      r_state;
    state_e                      w_next_state;
    id_ir_stage_t                r_out      [NUM_SCALAR_INSTR];
    id_ir_stage_t                w_out_next [NUM_SCALAR_INSTR];
    logic [CNT_WIDTH-1:0]        r_dual_cnt;
    logic [CNT_WIDTH-1:0]        r_split_cnt;
    logic [NUM_SCALAR_INSTR-1:0] w_pop;
    logic                        w_split;
    logic                        w_v0;
    logic                        w_v1;
    logic                        w_dep;
    logic                        w_ser0;
    logic                        w_ser1;
    logic                        w_go;

    assign w_v0   = !empty_i && instruction_S_i[0].instr.valid;
    assign w_v1   = w_v0 && instruction_S_i[1].instr.valid;
    assign w_ser0 = instruction_S_i[0].instr.stall_csr_fence;
    assign w_ser1 = instruction_S_i[1].instr.stall_csr_fence;
    assign w_dep  = instruction_S_i[0].instr.regfile_we
                 && (instruction_S_i[0].instr.rd != 5'd0)
                 && ((instruction_S_i[1].instr.rs1 == instruction_S_i[0].instr.rd)
                  || (instruction_S_i[1].instr.rs2 == instruction_S_i[0].instr.rd));

    // Reset gates issue so the pop strobes read zero while reset is held.
    assign w_go = rstn_i && (r_state == RUN) && !stall_i && !flush_i;

    // NOTE: every signal driven here gets a default first so no latch is inferred.
    always_comb begin
        w_pop        = '0;
        w_split      = 1'b0;
        w_next_state = r_state;
        if (flush_i) begin
            w_next_state = RUN;
        end else if (r_state == WAIT_SERIAL) begin
            if (serial_done_i) w_next_state = RUN;
        end else if (w_go && w_v0) begin
            w_pop[0] = 1'b1;
            if (w_ser0) begin
                w_next_state = WAIT_SERIAL;
            end else if (w_v1 && !w_dep && !w_ser1) begin
                w_pop[1] = 1'b1;
            end else if (w_v1) begin
                w_split = 1'b1;
            end
        end
    end

    always_comb begin
        w_out_next = r_out;
        if (flush_i || (!stall_i && r_state == WAIT_SERIAL)) begin
            w_out_next = '{default: '0};
        end else if (!stall_i) begin
            for (int s = 0; s < NUM_SCALAR_INSTR; s++)
                w_out_next[s] = w_pop[s] ? instruction_S_i[s] : '0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state     <= RUN;
            r_out       <= '{default: '0};
            r_dual_cnt  <= '0;
            r_split_cnt <= '0;
        end else begin
            r_state <= w_next_state;
            r_out   <= w_out_next;
            if ((&w_pop) && (r_dual_cnt != '1))
                r_dual_cnt <= r_dual_cnt + 1'b1;
            if (w_split && (r_split_cnt != '1))
                r_split_cnt <= r_split_cnt + 1'b1;
        end
    end

    assign read_head_S_o   = w_pop;
    assign instruction_S_o = r_out;
    assign serial_busy_o   = (r_state == WAIT_SERIAL);
    assign dual_cnt_o      = r_dual_cnt;
    assign split_cnt_o     = r_split_cnt;

endmodule

// File: tb/tb_ir_dual_dispatch.sv
// Scoreboard bench for ir_dual_dispatch: a queue model feeds the head, a monitor checks issued order.

module tb_ir_dual_dispatch;
    import ir_dual_dispatch_pkg::*;

    localparam int CW = 4;

    logic                        clk_i = 1'b0;
    logic                        rstn_i = 1'b0;
    id_ir_stage_t                instruction_S_i [NUM_SCALAR_INSTR];
    logic                        empty_i = 1'b1;
    logic                        flush_i = 1'b0;
    logic                        stall_i = 1'b0;
    logic                        serial_done_i = 1'b0;
    logic [NUM_SCALAR_INSTR-1:0] read_head_S_o;
    id_ir_stage_t                instruction_S_o [NUM_SCALAR_INSTR];
    logic                        serial_busy_o;
    logic [CW-1:0]               dual_cnt_o;
    logic [CW-1:0]               split_cnt_o;

    ir_dual_dispatch #(.CNT_WIDTH(CW)) dut (
        .clk_i           (clk_i),
        .rstn_i          (rstn_i),
        .instruction_S_i (instruction_S_i),
        .empty_i         (empty_i),
        .flush_i         (flush_i),
        .stall_i         (stall_i),
        .serial_done_i   (serial_done_i),
        .read_head_S_o   (read_head_S_o),
        .instruction_S_o (instruction_S_o),
        .serial_busy_o   (serial_busy_o),
        .dual_cnt_o      (dual_cnt_o),
        .split_cnt_o     (split_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    id_ir_stage_t iq[$];
    id_ir_stage_t exp_q[$];
    int           n_vec = 0;
    int           n_err = 0;
    bit           mon_load = 1'b0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    function automatic id_ir_stage_t mk(input logic [31:0] pc, input logic [4:0] rd,
                                        input logic [4:0] rs1, input logic [4:0] rs2,
                                        input logic we, input logic ser);
        id_ir_stage_t x;
        x.instr.valid           = 1'b1;
        x.instr.pc              = pc;
        x.instr.rd              = rd;
        x.instr.rs1             = rs1;
        x.instr.rs2             = rs2;
        x.instr.regfile_we      = we;
        x.instr.stall_csr_fence = ser;
        x.imm                   = pc ^ 32'hA5A5_0000;
        return x;
    endfunction

    task automatic drive_head();
        instruction_S_i[0] = (iq.size() > 0) ? iq[0] : '0;
        instruction_S_i[1] = (iq.size() > 1) ? iq[1] : '0;
        empty_i            = (iq.size() == 0);
    endtask

    task automatic push(input id_ir_stage_t x, input bit expect_issue);
        iq.push_back(x);
        if (expect_issue) exp_q.push_back(x);
        drive_head();
    endtask

    // One clock: check the pop strobes mid-cycle, then advance the queue model on the edge.
    task automatic tick(input logic [1:0] ep, input string nm);
        logic [1:0] p;
        @(negedge clk_i);
        check({nm, " pops"}, {30'd0, read_head_S_o}, {30'd0, ep});
        p = read_head_S_o;
        @(posedge clk_i);
        #1;
        if (p[0] && iq.size() > 0) iq.delete(0);
        if (p[1] && iq.size() > 0) iq.delete(0);
        drive_head();
    endtask

    always @(posedge clk_i) mon_load = rstn_i && !stall_i;

    always @(negedge clk_i) begin
        if (mon_load) begin
            if (instruction_S_o[1].instr.valid && !instruction_S_o[0].instr.valid) begin
                n_vec++;
                n_err++;
                $display("FAIL slot order: slot1 valid while slot0 invalid, pc %0h",
                         instruction_S_o[1].instr.pc);
            end
            for (int s = 0; s < NUM_SCALAR_INSTR; s++) begin
                if (instruction_S_o[s].instr.valid) begin
                    n_vec++;
                    if (exp_q.size() == 0) begin
                        n_err++;
                        $display("FAIL unexpected issue: slot %0d pc %0h, expected none",
                                 s, instruction_S_o[s].instr.pc);
                    end else begin
                        id_ir_stage_t e;
                        e = exp_q.pop_front();
                        if (instruction_S_o[s] !== e) begin
                            n_err++;
                            $display("FAIL issue slot %0d: got pc %0h imm %0h, expected pc %0h imm %0h",
                                     s, instruction_S_o[s].instr.pc, instruction_S_o[s].imm,
                                     e.instr.pc, e.imm);
                        end
                    end
                end
            end
        end
    end

    initial begin
        drive_head();
        #1;
        check("reset pops", {30'd0, read_head_S_o}, 32'd0);
        check("reset busy", {31'd0, serial_busy_o}, 32'd0);
        check("reset dual", {28'd0, dual_cnt_o}, 32'd0);
        check("reset split", {28'd0, split_cnt_o}, 32'd0);
        check("reset out valid", {30'd0, instruction_S_o[1].instr.valid, instruction_S_o[0].instr.valid}, 32'd0);
        repeat (2) @(posedge clk_i);
        #1 rstn_i = 1'b1;

        // Independent pair dual-issues.
        push(mk(32'h100, 5'd1, 5'd0, 5'd0, 1'b1, 1'b0), 1'b1);
        push(mk(32'h104, 5'd2, 5'd3, 5'd0, 1'b1, 1'b0), 1'b1);
        tick(2'b11, "indep");
        check("indep dual", {28'd0, dual_cnt_o}, 32'd1);
        tick(2'b00, "idle");

        // Dependent pair splits; the second issues alone next cycle.
        push(mk(32'h108, 5'd5, 5'd1, 5'd0, 1'b1, 1'b0), 1'b1);
        push(mk(32'h10c, 5'd6, 5'd5, 5'd0, 1'b1, 1'b0), 1'b1);
        tick(2'b01, "dep");
        check("dep split", {28'd0, split_cnt_o}, 32'd1);
        tick(2'b01, "dep tail");
        check("dep tail split", {28'd0, split_cnt_o}, 32'd1);

        // Writing x0 is not a hazard.
        push(mk(32'h110, 5'd0, 5'd1, 5'd0, 1'b1, 1'b0), 1'b1);
        push(mk(32'h114, 5'd7, 5'd0, 5'd0, 1'b1, 1'b0), 1'b1);
        tick(2'b11, "rd0 pair");
        check("rd0 dual", {28'd0, dual_cnt_o}, 32'd2);

        // Slot 1 valid with slot 0 invalid is ignored.
        instruction_S_i[0] = '0;
        instruction_S_i[1] = mk(32'h1f0, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0);
        empty_i            = 1'b0;
        tick(2'b00, "slot1 only");

        // Serialising instruction in slot 0 blocks issue until serial_done.
        push(mk(32'h118, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1), 1'b1);
        push(mk(32'h11c, 5'd8, 5'd0, 5'd0, 1'b1, 1'b0), 1'b1);
        tick(2'b01, "csr issue");
        check("csr busy", {31'd0, serial_busy_o}, 32'd1);
        check("csr no split", {28'd0, split_cnt_o}, 32'd1);
        for (int i = 0; i < 4; i++) begin
            tick(2'b00, "csr wait");
            check("csr wait busy", {31'd0, serial_busy_o}, 32'd1);
        end
        serial_done_i = 1'b1;
        tick(2'b00, "csr done cycle");
        serial_done_i = 1'b0;
        check("csr busy clear", {31'd0, serial_busy_o}, 32'd0);
        tick(2'b01, "csr resume");

        // Stall holds both pops and the pipeline register.
        push(mk(32'h120, 5'd9, 5'd0, 5'd0, 1'b1, 1'b0), 1'b1);
        push(mk(32'h124, 5'd10, 5'd0, 5'd0, 1'b1, 1'b0), 1'b1);
        stall_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick(2'b00, "stall");
            check("stall hold pc", instruction_S_o[0].instr.pc, 32'h11c);
            check("stall hold valid", {31'd0, instruction_S_o[0].instr.valid}, 32'd1);
        end
        stall_i = 1'b0;
        tick(2'b11, "stall release");
        check("stall dual", {28'd0, dual_cnt_o}, 32'd3);

        // Serialising instruction in slot 1 waits until it reaches slot 0.
        push(mk(32'h128, 5'd11, 5'd0, 5'd0, 1'b1, 1'b0), 1'b1);
        push(mk(32'h12c, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1), 1'b1);
        tick(2'b01, "ser1 split");
        check("ser1 split cnt", {28'd0, split_cnt_o}, 32'd2);
        tick(2'b01, "ser1 issue");
        check("ser1 busy", {31'd0, serial_busy_o}, 32'd1);
        serial_done_i = 1'b1;
        tick(2'b00, "ser1 done");
        serial_done_i = 1'b0;
        check("ser1 busy clear", {31'd0, serial_busy_o}, 32'd0);

        // Flush while waiting on a serialising instruction.
        push(mk(32'h130, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1), 1'b1);
        tick(2'b01, "csr2 issue");
        check("csr2 busy", {31'd0, serial_busy_o}, 32'd1);
        flush_i = 1'b1;
        tick(2'b00, "flush wait");
        flush_i = 1'b0;
        check("flush busy", {31'd0, serial_busy_o}, 32'd0);
        check("flush out", {30'd0, instruction_S_o[1].instr.valid, instruction_S_o[0].instr.valid}, 32'd0);

        // Flush in RUN with a full head wins over issue.
        push(mk(32'h134, 5'd12, 5'd0, 5'd0, 1'b1, 1'b0), 1'b0);
        push(mk(32'h138, 5'd13, 5'd0, 5'd0, 1'b1, 1'b0), 1'b0);
        flush_i = 1'b1;
        tick(2'b00, "flush run");
        flush_i = 1'b0;
        iq.delete();
        drive_head();
        check("flush run out", {30'd0, instruction_S_o[1].instr.valid, instruction_S_o[0].instr.valid}, 32'd0);
        check("flush keeps dual", {28'd0, dual_cnt_o}, 32'd3);
        check("flush keeps split", {28'd0, split_cnt_o}, 32'd2);

        // Twenty dual-issue cycles saturate the 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            push(mk(32'h200 + 32'(8 * i), 5'((i % 15) + 1), 5'd0, 5'd0, 1'b1, 1'b0), 1'b1);
            push(mk(32'h204 + 32'(8 * i), 5'((i % 15) + 16), 5'd0, 5'd0, 1'b1, 1'b0), 1'b1);
        end
        for (int i = 0; i < 20; i++) tick(2'b11, "burst");
        tick(2'b00, "burst drain");
        check("dual saturate", {28'd0, dual_cnt_o}, 32'd15);
        check("split after burst", {28'd0, split_cnt_o}, 32'd2);

        // Asynchronous reset in the middle of a burst.
        for (int i = 0; i < 10; i++) begin
            push(mk(32'h400 + 32'(8 * i), 5'((i % 15) + 1), 5'd0, 5'd0, 1'b1, 1'b0), 1'b1);
            push(mk(32'h404 + 32'(8 * i), 5'((i % 15) + 16), 5'd0, 5'd0, 1'b1, 1'b0), 1'b1);
        end
        for (int i = 0; i < 4; i++) tick(2'b11, "burst2");
        @(negedge clk_i);
        #1;
        check("pending before reset", exp_q.size(), iq.size());
        rstn_i = 1'b0;
        #1;
        check("mid reset pops", {30'd0, read_head_S_o}, 32'd0);
        check("mid reset busy", {31'd0, serial_busy_o}, 32'd0);
        check("mid reset dual", {28'd0, dual_cnt_o}, 32'd0);
        check("mid reset split", {28'd0, split_cnt_o}, 32'd0);
        check("mid reset out", {30'd0, instruction_S_o[1].instr.valid, instruction_S_o[0].instr.valid}, 32'd0);
        check("mid reset pc", instruction_S_o[0].instr.pc, 32'd0);
        iq.delete();
        exp_q.delete();
        drive_head();
        @(posedge clk_i);
        #1 rstn_i = 1'b1;

        push(mk(32'h500, 5'd3, 5'd0, 5'd0, 1'b1, 1'b0), 1'b1);
        push(mk(32'h504, 5'd4, 5'd0, 5'd0, 1'b1, 1'b0), 1'b1);
        tick(2'b11, "post reset");
        check("post reset dual", {28'd0, dual_cnt_o}, 32'd1);
        tick(2'b00, "final drain");
        check("scoreboard empty", exp_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
